// File: rtl/wm8731_ctrl_writer.sv
// WM8731 control-port write engine: serialises one 7+9 bit register write as
// a 3-byte two-wire frame (START, dev/W, ACK, byte1, ACK, byte2, ACK, STOP),
// paced by a one-cycle quarter-bit strobe.
module wm8731_ctrl_writer #(
  parameter logic [6:0] DEV_ADDR = 7'b0011010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qtick,
  input  logic       start,
  input  logic [6:0] reg_addr,
  input  logic [8:0] reg_data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  typedef enum logic [2:0] {IDLE, START, BITS, STOP, DONE} state_t;

  state_t      state;
  logic [1:0]  q;
  logic [4:0]  slot;
  logic [26:0] frame;
  logic [1:0]  sda_sync;
  logic        cur_bit;
  logic        is_ack;

  // ACK positions hold 1 in the frame so the data path releases SDA there.
  assign cur_bit = frame[5'd26 - slot];
  assign is_ack  = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);

  // Two-flop synchroniser for the asynchronous SDA pad input
  always_ff @(posedge clk) begin
    if (reset) sda_sync <= 2'b11;
    else       sda_sync <= {sda_sync[0], sda_in};
  end

  // Frame sequencer; every bus action happens on a quarter tick
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= 2'd0;
      slot    <= 5'd0;
      frame   <= '0;
      scl     <= 1'b1;
      sda_low <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A qtick coincident with start is deliberately not consumed.
          if (start) begin
            frame   <= {DEV_ADDR, 1'b0, 1'b1, reg_addr, reg_data[8], 1'b1,
                        reg_data[7:0], 1'b1};
            busy    <= 1'b1;
            ack_err <= 1'b0;
            q       <= 2'd0;
            slot    <= 5'd0;
            state   <= START;
          end
        end
        START: if (qtick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: begin scl <= 1'b1; sda_low <= 1'b0; end
            2'd2: sda_low <= 1'b1;
            2'd3: begin scl <= 1'b0; slot <= 5'd0; state <= BITS; end
            default: ;
          endcase
        end
        BITS: if (qtick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: begin scl <= 1'b0; sda_low <= ~cur_bit; end
            2'd1: scl <= 1'b1;
            2'd2: begin
              scl <= 1'b1;
              // A NACK is recorded but the frame runs to completion.
              if (is_ack && sda_sync[1]) ack_err <= 1'b1;
            end
            default: begin
              scl <= 1'b0;
              if (slot == 5'd26) state <= STOP;
              else               slot  <= slot + 5'd1;
            end
          endcase
        end
        STOP: if (qtick) begin
          q <= q + 2'd1;
          case (q)
            2'd0: begin scl <= 1'b0; sda_low <= 1'b1; end
            2'd1: scl <= 1'b1;
            2'd2: sda_low <= 1'b0;
            default: begin done <= 1'b1; busy <= 1'b0; state <= DONE; end
          endcase
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_ctrl_writer.sv
// Self-checking bench for wm8731_ctrl_writer: a bus monitor decodes the
// two-wire traffic and a slave model answers ACK slots; each frame is checked
// against bytes derived directly from the register write request.
module tb_wm8731_ctrl_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       qtick = 1'b0;
  logic       start = 1'b0;
  logic [6:0] reg_addr = '0;
  logic [8:0] reg_data = '0;
  logic       sda_in;
  logic       scl, sda_low, busy, done, ack_err;

  int total = 0;
  int bad = 0;
  int qp = 6;
  int qcnt = 0;

  wm8731_ctrl_writer dut (
    .clk(clk), .reset(reset), .qtick(qtick), .start(start),
    .reg_addr(reg_addr), .reg_data(reg_data), .sda_in(sda_in),
    .scl(scl), .sda_low(sda_low), .busy(busy), .done(done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  // quarter-bit strobe: one clk high every qp clocks
  always @(posedge clk) begin
    if (qcnt >= qp - 1) begin qcnt <= 0; qtick <= 1'b1; end
    else begin qcnt <= qcnt + 1; qtick <= 1'b0; end
  end

  // slave + bus model: f counts SCL falls since the start condition;
  // slot s is in progress while f == s+1
  int   f = 0;
  int   nack = 0;
  logic ack_pull;
  logic bits[$];
  int   starts = 0, stops = 0, dones = 0;
  logic pscl = 1'b1, psda = 1'b0;

  assign ack_pull = ((f == 9) || (f == 18) || (f == 27)) && (f != 9 * nack);
  assign sda_in   = ~sda_low & ~ack_pull;

  always @(negedge clk) begin
    if (scl && pscl && sda_low && !psda) begin
      starts++; f = 0; bits.delete();
    end else if (scl && pscl && !sda_low && psda) begin
      stops++;
    end
    if (scl && !pscl && f >= 1 && f <= 27) bits.push_back(sda_in);
    if (!scl && pscl) f++;
    if (done) dones++;
    pscl = scl;
    psda = sda_low;
  end

  function automatic logic [26:0] model_frame(input logic [6:0] a,
                                              input logic [8:0] d,
                                              input int nk);
    logic [7:0] b0, b1, b2;
    b0 = 8'h1A * 2;             // 7-bit device address 0x1A, write
    b1 = a * 2 + d / 256;
    b2 = d % 256;
    return {b0, logic'(nk == 1), b1, logic'(nk == 2), b2, logic'(nk == 3)};
  endfunction

  // Runs one frame; optional start injection at slot inj, start on the
  // DONE cycle, or start aligned with a qtick.
  task automatic run_frame(input logic [6:0] a, input logic [8:0] d,
                           input int nk, input bit coincide, input int inj,
                           input bit start_on_done);
    int n, lim, s0, p0, d0;
    bit injd;
    logic [26:0] exp, got;
    nack = nk; injd = 0;
    s0 = starts; p0 = stops; d0 = dones;
    @(negedge clk);
    if (coincide) begin
      lim = 0;
      while (!qtick && lim < 1000) begin @(negedge clk); lim++; end
    end
    reg_addr = a; reg_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || ack_err !== 1'b0) begin
      bad++; $display("FAIL accept: busy=%b ack_err=%b want 1 0", busy, ack_err);
    end
    n = 0; lim = 0;
    while (!done && lim < 200 * qp) begin
      start = 1'b0;
      if (inj > 0 && !injd && bits.size() == inj + 1) begin
        start = 1'b1; reg_addr = ~a; reg_data = ~d; injd = 1;
      end
      if (qtick) n++;
      @(negedge clk);
      lim++;
    end
    start = 1'b0;
    total++;
    if (!done) begin
      bad++; $display("FAIL done_timeout: no done after %0d clk", lim);
    end
    total++;
    if (n != 116) begin bad++; $display("FAIL frame_len: got %0d qticks want 116", n); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done: got %b want 0", busy); end
    exp = model_frame(a, d, nk);
    got = 'x;
    if (bits.size() == 27) for (int i = 0; i < 27; i++) got[26 - i] = bits[i];
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL frame_bits: got %h (%0d bits) want %h", got, bits.size(), exp);
    end
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL after_done: done=%b busy=%b want 0 0", done, busy);
    end
    total++;
    if (ack_err !== (nk != 0)) begin
      bad++; $display("FAIL ack_err: got %b want %b", ack_err, nk != 0);
    end
    total++;
    if (starts - s0 != 1 || stops - p0 != 1 || dones - d0 != 1) begin
      bad++; $display("FAIL bus_events: starts=%0d stops=%0d dones=%0d want 1 1 1",
                      starts - s0, stops - p0, dones - d0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (scl !== 1'b1 || sda_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0) begin
      bad++; $display("FAIL reset: scl=%b sda_low=%b busy=%b done=%b ack_err=%b want 1 0 0 0 0",
                      scl, sda_low, busy, done, ack_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle_qtick();
    repeat (4 * qp) @(negedge clk);
    total++;
    if (scl !== 1'b1 || sda_low !== 1'b0 || busy !== 1'b0 || dones != 0) begin
      bad++; $display("FAIL idle_qtick: scl=%b sda_low=%b busy=%b dones=%0d want 1 0 0 0",
                      scl, sda_low, busy, dones);
    end
  endtask

  task automatic test_basic();
    qp = 125;
    run_frame(7'h0F, 9'h000, 0, 0, 0, 0);
    qp = 6;
  endtask

  task automatic test_pattern();
    run_frame(7'h07, 9'h14A, 0, 0, 0, 0);
  endtask

  task automatic test_nack();
    run_frame(7'h05, 9'h0AA, 2, 0, 0, 0);
    repeat (3 * qp) @(negedge clk);
    total++;
    if (ack_err !== 1'b1) begin bad++; $display("FAIL ack_err_sticky: got %b want 1", ack_err); end
    run_frame(7'h06, 9'h155, 0, 0, 0, 0);
  endtask

  task automatic test_start_while_busy();
    run_frame(7'h2A, 9'h0C3, 0, 0, 5, 0);
  endtask

  task automatic test_back_to_back();
    int d0;
    run_frame(7'h11, 9'h1F0, 0, 0, 0, 1);
    d0 = dones;
    repeat (2 * qp) @(negedge clk);
    total++;
    if (busy !== 1'b0 || dones != d0 || scl !== 1'b1) begin
      bad++; $display("FAIL start_in_done: busy=%b extra_dones=%0d scl=%b want 0 0 1",
                      busy, dones - d0, scl);
    end
    run_frame(7'h12, 9'h00F, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int lim, d0;
    nack = 0;
    d0 = dones;
    @(negedge clk);
    reg_addr = 7'h33; reg_data = 9'h099; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (bits.size() != 13 && lim < 200 * qp) begin @(negedge clk); lim++; end
    total++;
    if (bits.size() != 13) begin bad++; $display("FAIL reset_mid_wait: bits=%0d want 13", bits.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (scl !== 1'b1 || sda_low !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_mid: scl=%b sda_low=%b busy=%b done=%b want 1 0 0 0",
                      scl, sda_low, busy, done);
    end
    repeat (3 * qp) @(negedge clk);
    total++;
    if (dones != d0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_nodone: dones=%0d busy=%b want 0 0", dones - d0, busy);
    end
    run_frame(7'h33, 9'h099, 0, 0, 0, 0);
  endtask

  task automatic test_coincident();
    run_frame(7'h4C, 9'h1B7, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      run_frame(7'($urandom), 9'($urandom), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_idle_qtick();
    test_basic();
    test_pattern();
    test_nack();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_coincident();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
